// File: rtl/growl_pkg.sv
// Shared encodings for the fetch path: next-pc selector codes, program-memory
// address selector codes, the NOP word and the two-word opcode classifier.
package growl_pkg;

   localparam logic [15:0] NOP = 16'h0000;

   typedef enum logic [2:0] {
      PC_INC    = 3'd0,
      PC_REL    = 3'd1,
      PC_BRANCH = 3'd2,
      PC_ABS    = 3'd3,
      PC_Z      = 3'd4,
      PC_RET    = 3'd5,
      PC_HOLD6  = 3'd6,
      PC_HOLD7  = 3'd7
   } pc_next_e;

   typedef enum logic [1:0] {
      ADDR_PC   = 2'd0,
      ADDR_PC1  = 2'd1,
      ADDR_Z    = 2'd2,
      ADDR_PC3  = 2'd3
   } imem_sel_e;

   // JMP/CALL (1001_010x_xxxx_11xx) and LDS/STS (1001_00xx_xxxx_0000) carry a
   // second program word; every other opcode is a single word.
   function automatic logic is_two_word(input logic [15:0] w);
      return ((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000);
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-pc and instruction-length logic for the fetch unit.
module pc_next_calc
   import growl_pkg::*;
(
   input  logic [15:0] pc,
   input  logic [15:0] inst,
   input  logic [15:0] raw_word,
   input  logic [15:0] k_word,
   input  logic [15:0] z_addr,
   input  logic [15:0] ret_addr,
   input  logic [2:0]  pc_next,
   input  logic        offset_mode,
   input  logic        branch_taken,
   input  logic        skip,
   output logic [15:0] next_pc,
   output logic [15:0] ret_pc
);

   logic [15:0] inst_len;
   logic [15:0] skip_len;
   logic [15:0] off;
   logic [15:0] pc_plus1;

   assign inst_len = is_two_word(inst)     ? 16'd2 : 16'd1;
   assign skip_len = is_two_word(raw_word) ? 16'd2 : 16'd1;
   assign pc_plus1 = pc + 16'd1;
   assign ret_pc   = pc + inst_len;

   // Relative offset: 12-bit form for RJMP/RCALL, 7-bit form for conditional branches.
   always_comb begin
      off = offset_mode ? {{4{inst[11]}}, inst[11:0]} : {{9{inst[9]}}, inst[9:3]};
   end

   // Select the completion target; a pending skip overrides the selector and
   // steps over the victim word, whose length comes from the raw fetched word.
   always_comb begin
      next_pc = pc;
      if (skip) begin
         next_pc = pc + skip_len;
      end else begin
         case (pc_next_e'(pc_next))
            PC_INC:    next_pc = ret_pc;
            PC_REL:    next_pc = pc_plus1 + off;
            PC_BRANCH: next_pc = branch_taken ? (pc_plus1 + off) : pc_plus1;
            PC_ABS:    next_pc = k_word;
            PC_Z:      next_pc = z_addr;
            PC_RET:    next_pc = ret_addr;
            PC_HOLD6:  next_pc = pc;
            PC_HOLD7:  next_pc = pc;
            default:   next_pc = pc;
         endcase
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, instruction register, second-word
// latch and one-cycle skip handling. The decoder sequences the per-instruction
// cycle index through c_next_state; this block stores it and exposes it on state.
module fetch_unit
   import growl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_data,
   input  logic [1:0]  c_next_state,
   input  logic        c_pc_stall,
   input  logic [2:0]  c_pc_next,
   input  logic        c_skip,
   input  logic        c_pc_offset_mode,
   input  logic [1:0]  c_imem_addr_sel,
   input  logic        branch_taken,
   input  logic [15:0] z_addr,
   input  logic [15:0] ret_addr,
   output logic [15:0] inst,
   output logic [1:0]  state,
   output logic [15:0] pc,
   output logic [15:0] ret_pc,
   output logic [15:0] k_word,
   output logic [15:0] lpm_data
);

   logic [1:0]  state_q;
   logic [15:0] pc_q;
   logic [15:0] ir_q;
   logic [15:0] k_word_q;
   logic        skip_q;

   logic        in_fetch;
   logic        skipping;
   logic        k_load;
   logic [15:0] k_word_fwd;
   logic [15:0] next_pc;

   assign in_fetch = (state_q == 2'd0);
   assign skipping = in_fetch && skip_q;
   assign k_load   = !in_fetch && (imem_sel_e'(c_imem_addr_sel) == ADDR_PC1);

   // An absolute jump completing in the same cycle that fetches its second
   // word must see that word, so the latch input is forwarded.
   assign k_word_fwd = k_load ? imem_data : k_word_q;

   // Program-memory address: the pc while fetching, else chosen by the decoder.
   always_comb begin
      imem_addr = pc_q;
      if (!in_fetch) begin
         case (imem_sel_e'(c_imem_addr_sel))
            ADDR_PC:  imem_addr = pc_q;
            ADDR_PC1: imem_addr = pc_q + 16'd1;
            ADDR_Z:   imem_addr = z_addr;
            ADDR_PC3: imem_addr = pc_q;
            default:  imem_addr = pc_q;
         endcase
      end
   end

   // Instruction to the decoder: live word in the fetch cycle (NOP while
   // skipping), latched copy in the later cycles of a multi-cycle instruction.
   always_comb begin
      inst = ir_q;
      if (in_fetch) begin
         inst = skip_q ? NOP : imem_data;
      end
   end

   pc_next_calc u_pc_next_calc (
      .pc           (pc_q),
      .inst         (inst),
      .raw_word     (imem_data),
      .k_word       (k_word_fwd),
      .z_addr       (z_addr),
      .ret_addr     (ret_addr),
      .pc_next      (c_pc_next),
      .offset_mode  (c_pc_offset_mode),
      .branch_taken (branch_taken),
      .skip         (skipping),
      .next_pc      (next_pc),
      .ret_pc       (ret_pc)
   );

   // Architectural state update; stall freezes everything, reset wins over stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= 2'd0;
         pc_q     <= 16'h0000;
         ir_q     <= NOP;
         k_word_q <= 16'h0000;
         skip_q   <= 1'b0;
      end else if (!c_pc_stall) begin
         if (in_fetch) begin
            ir_q <= imem_data;
         end
         if (k_load) begin
            k_word_q <= imem_data;
         end
         if (skipping) begin
            state_q <= 2'd0;
            pc_q    <= next_pc;
            skip_q  <= 1'b0;
         end else begin
            state_q <= c_next_state;
            if (c_next_state == 2'd0) begin
               pc_q <= next_pc;
               if (c_skip) begin
                  skip_q <= 1'b1;
               end
            end
         end
      end
   end

   assign state    = state_q;
   assign pc       = pc_q;
   assign k_word   = k_word_q;
   assign lpm_data = imem_data;

endmodule
